// File: rtl/ctrl_bus_pkg.sv
// Shared types for the control-bus initiator: FSM states, default bus widths
// and the command record shape {write, addr, data}.
package ctrl_bus_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/ctrl_initiator_if.sv
// Control bus between the initiator (master) and the responder (slave).
interface ctrl_initiator_if
  import ctrl_bus_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          ctrl_ready;
  logic          ctrl_write;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_data;
  logic          dut_cwait;
  logic          dut_cready;
  logic [DW-1:0] dut_data;
  logic [AW-1:0] dut_addr;

  modport master (
    output ctrl_ready, ctrl_write, ctrl_addr, ctrl_data,
    input  dut_cwait, dut_cready, dut_data, dut_addr
  );

  modport slave (
    input  ctrl_ready, ctrl_write, ctrl_addr, ctrl_data,
    output dut_cwait, dut_cready, dut_data, dut_addr
  );

endinterface

// File: rtl/ctrl_cmd_fifo.sv
// Synchronous show-ahead FIFO for queued bus commands; DEPTH must be a power of two.
module ctrl_cmd_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head entry is read combinationally so the initiator can pop and issue
  // in the same cycle; the queue is shallow enough for distributed RAM.
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_initiator.sv
// Queued control-bus initiator: commands are buffered, issued one at a time,
// and reads return a single-cycle response. Define CTRL_INITIATOR_TIMEOUT_EN for a read-wait abort.
module ctrl_initiator
  import ctrl_bus_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic                cmd_write,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [DW-1:0]       cmd_data,
  output logic                cmd_ready,
  ctrl_initiator_if.master    bus,
  output logic                rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic [AW-1:0]       rsp_addr,
  output logic                rsp_err,
  output logic                busy
);

  localparam int EW = 1 + AW + DW;

  logic [EW-1:0] fifo_wr_data;
  logic [EW-1:0] fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  state_t        state_reg, state_next;
  logic          ctrl_ready_reg, ctrl_ready_next;
  logic          ctrl_write_reg, ctrl_write_next;
  logic [AW-1:0] ctrl_addr_reg, ctrl_addr_next;
  logic [DW-1:0] ctrl_data_reg, ctrl_data_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0] rsp_data_reg, rsp_data_next;
  logic [AW-1:0] rsp_addr_reg, rsp_addr_next;
  logic          rsp_err_reg, rsp_err_next;

  assign fifo_wr_data = {cmd_write, cmd_addr, cmd_data};
  assign cmd_ready    = !fifo_full;

  ctrl_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid && cmd_ready),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef CTRL_INITIATOR_TIMEOUT_EN
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_hit;

  // Abort on the wait cycle that would bring the count up to TIMEOUT.
  assign timeout_hit = bus.dut_cwait && (wait_cnt_reg == 8'(TIMEOUT - 1));
`endif

  always_comb begin
    state_next      = state_reg;
    ctrl_ready_next = ctrl_ready_reg;
    ctrl_write_next = ctrl_write_reg;
    ctrl_addr_next  = ctrl_addr_reg;
    ctrl_data_next  = ctrl_data_reg;
    rsp_valid_next  = 1'b0;
    rsp_data_next   = rsp_data_reg;
    rsp_addr_next   = rsp_addr_reg;
    rsp_err_next    = rsp_err_reg;
    fifo_pop        = 1'b0;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
    wait_cnt_next   = wait_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          {ctrl_write_next, ctrl_addr_next, ctrl_data_next} = fifo_rd_data;
          ctrl_ready_next = 1'b1;
          state_next      = ISSUE;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
          wait_cnt_next   = '0;
`endif
        end
      end
      ISSUE: begin
        if (!bus.dut_cwait) begin
          ctrl_ready_next = 1'b0;
          state_next      = GAP;
          if (!ctrl_write_reg) begin
            rsp_valid_next = 1'b1;
            rsp_addr_next  = ctrl_addr_reg;
            rsp_err_next   = !bus.dut_cready;
            rsp_data_next  = bus.dut_cready ? bus.dut_data : '0;
          end
        end
`ifdef CTRL_INITIATOR_TIMEOUT_EN
        else if (!ctrl_write_reg) begin
          if (timeout_hit) begin
            ctrl_ready_next = 1'b0;
            state_next      = GAP;
            rsp_valid_next  = 1'b1;
            rsp_addr_next   = ctrl_addr_reg;
            rsp_err_next    = 1'b1;
            rsp_data_next   = '0;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
`endif
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      ctrl_ready_reg <= 1'b0;
      ctrl_write_reg <= 1'b0;
      ctrl_addr_reg  <= '0;
      ctrl_data_reg  <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_addr_reg   <= '0;
      rsp_err_reg    <= 1'b0;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
      wait_cnt_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      ctrl_ready_reg <= ctrl_ready_next;
      ctrl_write_reg <= ctrl_write_next;
      ctrl_addr_reg  <= ctrl_addr_next;
      ctrl_data_reg  <= ctrl_data_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_addr_reg   <= rsp_addr_next;
      rsp_err_reg    <= rsp_err_next;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
      wait_cnt_reg   <= wait_cnt_next;
`endif
    end
  end

  assign bus.ctrl_ready = ctrl_ready_reg;
  assign bus.ctrl_write = ctrl_write_reg;
  assign bus.ctrl_addr  = ctrl_addr_reg;
  assign bus.ctrl_data  = ctrl_data_reg;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_data       = rsp_data_reg;
  assign rsp_addr       = rsp_addr_reg;
  assign rsp_err        = rsp_err_reg;
  assign busy           = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_ctrl_initiator.sv
// Directed, table-driven bench for ctrl_initiator plus hand-written sequences
// for FIFO fill, reset mid-read and (when enabled) read timeout.
`timescale 1ns/1ps
module tb_ctrl_initiator;
  import ctrl_bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  ctrl_initiator_if #(.AW(AW), .DW(DW)) bus ();

  ctrl_initiator #(
    .AW        (AW),
    .DW        (DW),
    .CMD_DEPTH (4),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .bus       (bus),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    cmd_entry_t  cmd;
    int          n_wait;
    logic        cready;
    logic [31:0] rdata;
    logic        exp_rsp;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  logic [31:0] m_rsp_data;
  logic [15:0] m_rsp_addr;
  logic        m_rsp_err;

  function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [31:0] d,
                              input int nw, input logic cr, input logic [31:0] rd,
                              input logic er, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.cmd.write = w;
    v.cmd.addr  = a;
    v.cmd.data  = d;
    v.n_wait    = nw;
    v.cready    = cr;
    v.rdata     = rd;
    v.exp_rsp   = er;
    v.exp_data  = ed;
    v.exp_err   = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ctrl_ready(input int max_cycles, output int n);
    n = 0;
    while (!bus.ctrl_ready && n < max_cycles) begin
      tick();
      n++;
    end
    chk("ctrl_ready_seen", bus.ctrl_ready, 1);
  endtask

  task automatic push_cmd(input logic w, input logic [15:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hi;
    int dbl;
    int nrsp;
    int nrdy;
    logic prev_rdy;
    logic [15:0] issued [$];

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    bus.dut_cwait = 1'b0;
    bus.dut_cready = 1'b0;
    bus.dut_data = '0;
    bus.dut_addr = '0;
    m_rsp_data = '0;
    m_rsp_addr = '0;
    m_rsp_err = 1'b0;

    vecs[0] = mk(1'b1, 16'h0100, 32'h0000_0001, 0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0);
    vecs[1] = mk(1'b0, 16'h0208, 32'h0,         1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
    vecs[2] = mk(1'b0, 16'h0010, 32'h0,         0, 1'b0, 32'h55AA_55AA, 1'b1, 32'h0,         1'b1);
    vecs[3] = mk(1'b1, 16'h1234, 32'hA5A5_A5A5, 3, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0);
    vecs[4] = mk(1'b0, 16'hFFFF, 32'h0,         2, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0);

    // Reset state
    tick();
    tick();
    chk("rst_ctrl_ready", bus.ctrl_ready, 0);
    chk("rst_ctrl_write", bus.ctrl_write, 0);
    chk("rst_ctrl_addr", bus.ctrl_addr, 0);
    chk("rst_ctrl_data", bus.ctrl_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 5; i++) begin
      bus.dut_cwait  = (vecs[i].n_wait > 0);
      bus.dut_cready = 1'b0;
      bus.dut_data   = '0;
      push_cmd(vecs[i].cmd.write, vecs[i].cmd.addr, vecs[i].cmd.data);
      chk("cmd_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      wait_ctrl_ready(10, lat);
      chk("issue_latency", lat, 1);
      chk("ctrl_write", bus.ctrl_write, vecs[i].cmd.write);
      chk("ctrl_addr", bus.ctrl_addr, vecs[i].cmd.addr);
      chk("ctrl_data", bus.ctrl_data, vecs[i].cmd.data);
      for (int w = 0; w < vecs[i].n_wait; w++) begin
        tick();
        chk("hold_ctrl_ready", bus.ctrl_ready, 1);
        chk("hold_ctrl_addr", bus.ctrl_addr, vecs[i].cmd.addr);
        chk("hold_ctrl_data", bus.ctrl_data, vecs[i].cmd.data);
        chk("hold_ctrl_write", bus.ctrl_write, vecs[i].cmd.write);
        chk("hold_no_rsp", rsp_valid, 0);
      end
      bus.dut_cwait  = 1'b0;
      bus.dut_cready = vecs[i].cready;
      bus.dut_data   = vecs[i].rdata;
      tick();
      chk("done_ctrl_ready", bus.ctrl_ready, 0);
      chk("rsp_valid", rsp_valid, vecs[i].exp_rsp);
      if (vecs[i].exp_rsp) begin
        m_rsp_data = vecs[i].exp_data;
        m_rsp_addr = vecs[i].cmd.addr;
        m_rsp_err  = vecs[i].exp_err;
      end
      chk("rsp_data", rsp_data, m_rsp_data);
      chk("rsp_addr", rsp_addr, m_rsp_addr);
      chk("rsp_err", rsp_err, m_rsp_err);
      bus.dut_cready = 1'b0;
      bus.dut_data   = 32'h0BAD_F00D;
      tick();
      chk("rsp_pulse_end", rsp_valid, 0);
      chk("gap_ctrl_ready", bus.ctrl_ready, 0);
      chk("rsp_data_hold", rsp_data, m_rsp_data);
      chk("rsp_err_hold", rsp_err, m_rsp_err);
      chk("idle_busy", busy, 0);
      $display("txn %0d write=%0b addr=0x%04h wait=%0d rsp_valid_exp=%0b rsp_data=0x%08h rsp_err=%0b",
               i, vecs[i].cmd.write, vecs[i].cmd.addr, vecs[i].n_wait, vecs[i].exp_rsp,
               rsp_data, rsp_err);
    end

    // FIFO fill while the bus is stalled, then drain in order
    bus.dut_cwait = 1'b1;
    push_cmd(1'b1, 16'h0A00, 32'h0);
    tick();
    cmd_valid = 1'b0;
    wait_ctrl_ready(10, lat);
    for (int j = 1; j <= 4; j++) begin
      push_cmd(1'b1, 16'(16'h0A00 + j), 32'(j));
      chk("cmd_ready_fill", cmd_ready, 1);
      tick();
    end
    push_cmd(1'b1, 16'h0A05, 32'h5);
    chk("cmd_ready_full", cmd_ready, 0);
    chk("busy_full", busy, 1);
    tick();
    chk("cmd_ready_full_hold", cmd_ready, 0);
    chk("stalled_ctrl_ready", bus.ctrl_ready, 1);
    bus.dut_cwait = 1'b0;
    tick();
    chk("full_after_done", cmd_ready, 0);
    chk("done_ctrl_ready_fill", bus.ctrl_ready, 0);
    tick();
    chk("full_in_gap", cmd_ready, 0);
    tick();
    chk("first_pop_ready", bus.ctrl_ready, 1);
    chk("first_pop_addr", bus.ctrl_addr, 16'h0A01);
    chk("cmd_ready_after_pop", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("single_cycle_issue", bus.ctrl_ready, 0);
    prev_rdy = bus.ctrl_ready;
    dbl = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ctrl_ready && !prev_rdy) issued.push_back(bus.ctrl_addr);
      if (bus.ctrl_ready && prev_rdy) dbl++;
      prev_rdy = bus.ctrl_ready;
    end
    chk("drain_issue_count", issued.size(), 4);
    for (int k = 0; k < issued.size(); k++) begin
      chk("drain_order", issued[k], 16'(16'h0A02 + k));
    end
    chk("drain_back_to_back", dbl, 0);
    chk("drain_busy", busy, 0);
    chk("drain_cmd_ready", cmd_ready, 1);
    $display("txn fifo_fill issued=%0d", issued.size() + 1);

    // Reset asserted while a read is held
    bus.dut_cwait = 1'b1;
    push_cmd(1'b0, 16'h0300, 32'h0);
    tick();
    push_cmd(1'b1, 16'h0304, 32'h44);
    tick();
    cmd_valid = 1'b0;
    chk("held_read_ready", bus.ctrl_ready, 1);
    chk("held_read_addr", bus.ctrl_addr, 16'h0300);
    tick();
    chk("held_read_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("midrst_ctrl_ready", bus.ctrl_ready, 0);
    chk("midrst_ctrl_write", bus.ctrl_write, 0);
    chk("midrst_ctrl_addr", bus.ctrl_addr, 0);
    chk("midrst_ctrl_data", bus.ctrl_data, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_rsp_addr", rsp_addr, 0);
    chk("midrst_rsp_err", rsp_err, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    m_rsp_data = '0;
    m_rsp_addr = '0;
    m_rsp_err  = 1'b0;
    reset = 1'b0;
    bus.dut_cwait  = 1'b0;
    bus.dut_cready = 1'b1;
    bus.dut_data   = 32'hCAFE_0001;
    nrsp = 0;
    nrdy = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid) nrsp++;
      if (bus.ctrl_ready) nrdy++;
    end
    chk("postrst_no_rsp", nrsp, 0);
    chk("postrst_no_issue", nrdy, 0);
    bus.dut_cready = 1'b0;
    $display("txn reset_mid_read rsp_seen=%0d issues_seen=%0d", nrsp, nrdy);

`ifdef CTRL_INITIATOR_TIMEOUT_EN
    // Read stuck in wait is aborted, then the queued write issues
    bus.dut_cwait = 1'b1;
    push_cmd(1'b0, 16'h0400, 32'h0);
    tick();
    push_cmd(1'b1, 16'h0404, 32'h77);
    tick();
    cmd_valid = 1'b0;
    chk("to_read_ready", bus.ctrl_ready, 1);
    hi = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.ctrl_ready) hi++;
      else break;
    end
    chk("to_wait_cycles", hi, 8);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_addr", rsp_addr, 16'h0400);
    bus.dut_cwait = 1'b0;
    wait_ctrl_ready(10, lat);
    chk("to_next_addr", bus.ctrl_addr, 16'h0404);
    chk("to_next_write", bus.ctrl_write, 1);
    tick();
    chk("to_next_done", bus.ctrl_ready, 0);
    chk("to_next_no_rsp", rsp_valid, 0);
    $display("txn timeout_read wait_cycles=%0d", hi);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
